fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_pkg.sv | 14 +
 rtl/fetch_ctrl_if.sv | 44 ++++
 rtl/fetch_ctrl_sat_counter.sv | 23 ++
 rtl/fetch_ctrl.sv | 135 +++++++++++++
 tb/tb_fetch_ctrl.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - shared fetch-control types and widths
package fetch_ctrl_pkg;

  // Controller states: boot wait, normal fetch, halted
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam int REG_W     = 5;
  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - pipeline hazard inputs and fetch control outputs
interface fetch_ctrl_if
  import fetch_ctrl_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);

  logic             branch_taken;
  logic             id_ex_memread;
  logic [REG_W-1:0] id_ex_rd;
  logic [REG_W-1:0] if_id_rs;
  logic [REG_W-1:0] if_id_rt;
  logic             halt_req;
  logic             resume;
  logic             cnt_clr;

  logic             pc_write;
  logic             branch;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic             id_ex_bubble;
  logic             fetch_valid;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Pipeline side: reports hazards and consumes the control outputs
  modport master (
    output branch_taken, id_ex_memread, id_ex_rd, if_id_rs, if_id_rt,
           halt_req, resume, cnt_clr,
    input  pc_write, branch, if_id_write, if_id_flush, id_ex_flush,
           ex_mem_flush, id_ex_bubble, fetch_valid, stall_cnt, flush_cnt
  );

  // Controller side
  modport slave (
    input  branch_taken, id_ex_memread, id_ex_rd, if_id_rs, if_id_rt,
           halt_req, resume, cnt_clr,
    output pc_write, branch, if_id_write, if_id_flush, id_ex_flush,
           ex_mem_flush, id_ex_bubble, fetch_valid, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/fetch_ctrl_sat_counter.sv
// rtl/fetch_ctrl_sat_counter.sv - saturating event counter with sync clear
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  // Clear wins over increment; count sticks at all-ones
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - IF-stage control: boot wait, load-use stall, redirect, halt
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES = 2,
  parameter int CNT_W       = DEF_CNT_W
) (
  input logic        clk,
  input logic        rst,
  fetch_ctrl_if.slave bus
);

  localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

  state_t          state, state_nxt;
  logic [BW-1:0]   boot_cnt, boot_cnt_nxt;
  logic            boot_done;
  logic            hazard;
  logic            stall_inc, flush_inc;
  logic            pc_write, branch, if_id_write;
  logic            if_id_flush, id_ex_flush, ex_mem_flush;
  logic            id_ex_bubble, fetch_valid;
  logic [CNT_W-1:0] stall_q, flush_q;

  // A BOOT_CYCLES of 0 still spends one cycle in BOOT
  assign boot_done = (int'(boot_cnt) + 1 >= BOOT_CYCLES);

  // Load in EX writes a register the instruction in ID reads; r0 never hazards
  assign hazard = bus.id_ex_memread && (bus.id_ex_rd != '0) &&
                  ((bus.id_ex_rd == bus.if_id_rs) || (bus.id_ex_rd == bus.if_id_rt));

  // State and boot-wait counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= BOOT;
      boot_cnt <= '0;
    end else begin
      state    <= state_nxt;
      boot_cnt <= boot_cnt_nxt;
    end
  end

  // Next state and Mealy outputs; redirect beats halt, halt beats stall
  always_comb begin
    state_nxt    = state;
    boot_cnt_nxt = boot_cnt;
    pc_write     = 1'b0;
    branch       = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    id_ex_bubble = 1'b0;
    fetch_valid  = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    case (state)
      BOOT: begin
        if_id_flush = 1'b1;
        if (boot_done) begin
          state_nxt    = RUN;
          boot_cnt_nxt = '0;
        end else begin
          boot_cnt_nxt = boot_cnt + BW'(1);
        end
      end
      RUN: begin
        if (bus.branch_taken) begin
          branch       = 1'b1;
          pc_write     = 1'b1;
          if_id_write  = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = 1'b1;
          flush_inc    = 1'b1;
        end else if (bus.halt_req) begin
          state_nxt = HALT;
        end else if (hazard) begin
          id_ex_bubble = 1'b1;
          stall_inc    = 1'b1;
        end else begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
          fetch_valid = 1'b1;
        end
      end
      HALT: begin
        if (bus.branch_taken) begin
          branch       = 1'b1;
          pc_write     = 1'b1;
          if_id_write  = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = 1'b1;
          flush_inc    = 1'b1;
          state_nxt    = RUN;
        end else if (bus.resume) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt    = BOOT;
        boot_cnt_nxt = '0;
      end
    endcase
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .clr (bus.cnt_clr),
    .q   (stall_q)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_inc),
    .clr (bus.cnt_clr),
    .q   (flush_q)
  );

  assign bus.pc_write     = pc_write;
  assign bus.branch       = branch;
  assign bus.if_id_write  = if_id_write;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_flush  = id_ex_flush;
  assign bus.ex_mem_flush = ex_mem_flush;
  assign bus.id_ex_bubble = id_ex_bubble;
  assign bus.fetch_valid  = fetch_valid;
  assign bus.stall_cnt    = stall_q;
  assign bus.flush_cnt    = flush_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed scoreboard bench for fetch_ctrl
module tb_fetch_ctrl;

  // {pc_write, branch, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, id_ex_bubble, fetch_valid}
  localparam logic [7:0] BOOT_O  = 8'b0001_0000;
  localparam logic [7:0] RUN_O   = 8'b1010_0001;
  localparam logic [7:0] BR_O    = 8'b1111_1100;
  localparam logic [7:0] STALL_O = 8'b0000_0010;
  localparam logic [7:0] HALT_O  = 8'b0000_0000;

  typedef struct {
    string       tag;
    logic [7:0]  outs;
    logic [15:0] stall;
    logic [15:0] flush;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  logic [15:0] m_stall = '0;
  logic [15:0] m_flush = '0;

  fetch_ctrl_if #(.CNT_W(16)) bus ();

  fetch_ctrl #(.BOOT_CYCLES(2), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  wire [7:0] obs = {bus.pc_write, bus.branch, bus.if_id_write, bus.if_id_flush,
                    bus.id_ex_flush, bus.ex_mem_flush, bus.id_ex_bubble, bus.fetch_valid};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // Apply one cycle of inputs, score the Mealy outputs mid-cycle, then advance the model
  task automatic step(input string tag, input logic bt, input logic mr, input logic [4:0] rd,
                      input logic [4:0] rs, input logic [4:0] rt, input logic hr,
                      input logic rsm, input logic cc, input logic [7:0] want);
    exp_t e;
    bus.branch_taken  = bt;
    bus.id_ex_memread = mr;
    bus.id_ex_rd      = rd;
    bus.if_id_rs      = rs;
    bus.if_id_rt      = rt;
    bus.halt_req      = hr;
    bus.resume        = rsm;
    bus.cnt_clr       = cc;
    sb.push_back('{tag, want, m_stall, m_flush});
    @(negedge clk);
    e = sb.pop_front();
    chk({e.tag, ".outs"},  32'(obs),           32'(e.outs));
    chk({e.tag, ".stall"}, 32'(bus.stall_cnt), 32'(e.stall));
    chk({e.tag, ".flush"}, 32'(bus.flush_cnt), 32'(e.flush));
    @(posedge clk);
    #1;
    if (cc) begin
      m_stall = '0;
      m_flush = '0;
    end else begin
      if (want[1] && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
      if (want[6] && m_flush != 16'hFFFF) m_flush = m_flush + 16'd1;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.branch_taken  = 1'b0;
    bus.id_ex_memread = 1'b0;
    bus.id_ex_rd      = '0;
    bus.if_id_rs      = '0;
    bus.if_id_rt      = '0;
    bus.halt_req      = 1'b0;
    bus.resume        = 1'b0;
    bus.cnt_clr       = 1'b0;

    #2;
    chk("reset.outs",  32'(obs),           32'(BOOT_O));
    chk("reset.stall", 32'(bus.stall_cnt), 32'd0);
    chk("reset.flush", 32'(bus.flush_cnt), 32'd0);

    // Branch/resume asserted during boot must be ignored
    @(posedge clk);
    #1;
    rst = 1'b1;
    step("boot1", 1, 0, 0, 0, 0, 1, 1, 0, BOOT_O);
    step("boot2", 1, 0, 0, 0, 0, 0, 1, 0, BOOT_O);
    step("run",   0, 0, 0, 0, 0, 0, 0, 0, RUN_O);

    step("lu_rt",   0, 1, 5'd5, 5'd1, 5'd5, 0, 0, 0, STALL_O);
    step("idle",    0, 0, 5'd5, 5'd1, 5'd5, 0, 0, 0, RUN_O);
    step("rd0",     0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, RUN_O);
    step("lu_rs",   0, 1, 5'd3, 5'd3, 5'd7, 0, 0, 0, STALL_O);
    step("noload",  0, 0, 5'd5, 5'd5, 5'd5, 0, 0, 0, RUN_O);
    step("br_haz",  1, 1, 5'd5, 5'd1, 5'd5, 0, 0, 0, BR_O);
    step("br_halt", 1, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, BR_O);
    step("halt_req", 0, 1, 5'd5, 5'd5, 5'd5, 1, 0, 0, HALT_O);
    for (int i = 0; i < 10; i++)
      step("halt_hold", 0, 1, 5'd5, 5'd5, 5'd5, 0, 0, 0, HALT_O);
    step("halt_br_res", 1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, BR_O);
    step("after_res",   0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, RUN_O);
    step("halt2",       0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, HALT_O);
    step("resume",      0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, HALT_O);
    step("run2",        0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, RUN_O);

    // Drive a persistent hazard until the stall counter reaches all-ones
    bus.id_ex_memread = 1'b1;
    bus.id_ex_rd      = 5'd9;
    bus.if_id_rs      = 5'd9;
    bus.if_id_rt      = 5'd0;
    repeat (int'(16'hFFFF - m_stall)) @(posedge clk);
    #1;
    m_stall = 16'hFFFF;
    step("sat",     0, 1, 5'd9, 5'd9, 5'd0, 0, 0, 0, STALL_O);
    step("clr",     0, 1, 5'd9, 5'd9, 5'd0, 0, 0, 1, STALL_O);
    step("cleared", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, RUN_O);
    step("br2",     1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, BR_O);
    step("lu3",     0, 1, 5'd4, 5'd0, 5'd4, 0, 0, 0, STALL_O);
    step("halt3",   0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, HALT_O);
    chk("halt3.stall_pre", 32'(bus.stall_cnt), 32'(m_stall));

    // Reset between edges while halted
    bus.halt_req = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst.outs",  32'(obs),           32'(BOOT_O));
    chk("async_rst.stall", 32'(bus.stall_cnt), 32'd0);
    chk("async_rst.flush", 32'(bus.flush_cnt), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_held.outs", 32'(obs), 32'(BOOT_O));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
